// File: rtl/fractal_dispatcher.sv
// fractal_dispatcher: raster-scans a frame, hands each pixel's complex
// coordinate to the lowest-index idle fractal core, and returns each core's
// iteration count as a tagged (col,row,iter) result on a valid/ready stream.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   frame_start_i          start-of-frame pulse (honoured in IDLE only)
//   x_start_i, y_start_i   signed 8.24 coordinate of pixel (0,0)
//   step_i                 signed 8.24 per-pixel increment, both axes
//   width_i, height_i      frame size in pixels
//   max_iter_i / _o        iteration limit, latched per frame
//   start_o                per-core one-cycle start pulse
//   x0_o, y0_o             packed per-core coordinates (slice i = core i)
//   iter_i, done_i         packed per-core iteration results / done levels
//   res_valid_o/ready_i    result stream handshake
//   res_col_o/row_o/iter_o result payload
//   busy_o                 high whenever not IDLE
//   frame_done_o           one-cycle pulse at end of frame
module fractal_dispatcher #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MAX_ITER_WIDTH = 16,
    parameter int unsigned CORE_COUNT     = 16,
    parameter int unsigned COORD_WIDTH    = 12
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               frame_start_i,
    input  logic [DATA_WIDTH-1:0]              x_start_i,
    input  logic [DATA_WIDTH-1:0]              y_start_i,
    input  logic [DATA_WIDTH-1:0]              step_i,
    input  logic [COORD_WIDTH-1:0]             width_i,
    input  logic [COORD_WIDTH-1:0]             height_i,
    input  logic [MAX_ITER_WIDTH-1:0]          max_iter_i,
    output logic [CORE_COUNT-1:0]              start_o,
    output logic [DATA_WIDTH*CORE_COUNT-1:0]   x0_o,
    output logic [DATA_WIDTH*CORE_COUNT-1:0]   y0_o,
    output logic [MAX_ITER_WIDTH-1:0]          max_iter_o,
    input  logic [MAX_ITER_WIDTH*CORE_COUNT-1:0] iter_i,
    input  logic [CORE_COUNT-1:0]              done_i,
    output logic                               res_valid_o,
    input  logic                               res_ready_i,
    output logic [COORD_WIDTH-1:0]             res_col_o,
    output logic [COORD_WIDTH-1:0]             res_row_o,
    output logic [MAX_ITER_WIDTH-1:0]          res_iter_o,
    output logic                               busy_o,
    output logic                               frame_done_o
);

    localparam int unsigned IDX_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Frame parameters and raster position
    logic [DATA_WIDTH-1:0]     x_start_q, x_start_d, y_start_q, y_start_d;
    logic [DATA_WIDTH-1:0]     step_q, step_d, cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [COORD_WIDTH-1:0]    width_q, width_d, height_q, height_d;
    logic [COORD_WIDTH-1:0]    col_q, col_d, row_q, row_d;
    logic [MAX_ITER_WIDTH-1:0] max_iter_q, max_iter_d;

    // Per-core state
    logic [CORE_COUNT-1:0]                   cbusy_q, cbusy_d, armed_q, armed_d;
    logic [CORE_COUNT-1:0]                   start_q, start_d;
    logic [CORE_COUNT-1:0][COORD_WIDTH-1:0]  tag_col_q, tag_col_d, tag_row_q, tag_row_d;
    logic [CORE_COUNT-1:0][DATA_WIDTH-1:0]   x0_q, x0_d, y0_q, y0_d;

    // Result register and status
    logic                      res_valid_q, res_valid_d;
    logic [COORD_WIDTH-1:0]    res_col_q, res_col_d, res_row_q, res_row_d;
    logic [MAX_ITER_WIDTH-1:0] res_iter_q, res_iter_d;
    logic                      busy_q, busy_d, frame_done_q, frame_done_d;

    logic [CORE_COUNT-1:0][MAX_ITER_WIDTH-1:0] iter_w;
    logic [CORE_COUNT-1:0]     pend;
    logic                      free_found, pend_found, cap_ok;
    logic [IDX_W-1:0]          free_idx, pend_idx;

    assign iter_w = iter_i;

    // A done level only counts once the core has seen its start pulse
    assign pend   = cbusy_q & armed_q & done_i;
    // Output register can take a new entry when empty or being drained now
    assign cap_ok = !res_valid_q || res_ready_i;

    // Lowest-index idle core and lowest-index pending core
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        pend_found = 1'b0;
        pend_idx   = '0;
        for (int i = CORE_COUNT - 1; i >= 0; i--) begin
            if (!cbusy_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (pend[i]) begin
                pend_found = 1'b1;
                pend_idx   = IDX_W'(i);
            end
        end
    end

    // Next-state: FSM, dispatch, raster advance and result collection
    always_comb begin
        state_d      = state_q;
        x_start_d    = x_start_q;
        y_start_d    = y_start_q;
        step_d       = step_q;
        width_d      = width_q;
        height_d     = height_q;
        col_d        = col_q;
        row_d        = row_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        max_iter_d   = max_iter_q;
        cbusy_d      = cbusy_q;
        armed_d      = armed_q | start_q;
        start_d      = '0;
        tag_col_d    = tag_col_q;
        tag_row_d    = tag_row_q;
        x0_d         = x0_q;
        y0_d         = y0_q;
        res_valid_d  = res_valid_q;
        res_col_d    = res_col_q;
        res_row_d    = res_row_q;
        res_iter_d   = res_iter_q;
        frame_done_d = 1'b0;

        if (res_valid_q && res_ready_i) begin
            res_valid_d = 1'b0;
        end
        if (pend_found && cap_ok) begin
            res_valid_d       = 1'b1;
            res_col_d         = tag_col_q[pend_idx];
            res_row_d         = tag_row_q[pend_idx];
            res_iter_d        = iter_w[pend_idx];
            cbusy_d[pend_idx] = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (frame_start_i) begin
                    x_start_d  = x_start_i;
                    y_start_d  = y_start_i;
                    step_d     = step_i;
                    width_d    = width_i;
                    height_d   = height_i;
                    max_iter_d = max_iter_i;
                    col_d      = '0;
                    row_d      = '0;
                    cur_x_d    = x_start_i;
                    cur_y_d    = y_start_i;
                    state_d    = (width_i == '0 || height_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // cbusy_q is used, so a core freed this cycle waits a cycle
                if (free_found) begin
                    x0_d[free_idx]      = cur_x_q;
                    y0_d[free_idx]      = cur_y_q;
                    tag_col_d[free_idx] = col_q;
                    tag_row_d[free_idx] = row_q;
                    cbusy_d[free_idx]   = 1'b1;
                    armed_d[free_idx]   = 1'b0;
                    start_d[free_idx]   = 1'b1;
                    if (col_q == width_q - COORD_WIDTH'(1)) begin
                        col_d   = '0;
                        cur_x_d = x_start_q;
                        row_d   = row_q + COORD_WIDTH'(1);
                        cur_y_d = cur_y_q + step_q;
                        if (row_q == height_q - COORD_WIDTH'(1)) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        col_d   = col_q + COORD_WIDTH'(1);
                        cur_x_d = cur_x_q + step_q;
                    end
                end
            end
            S_DRAIN: begin
                if (cbusy_q == '0 && cap_ok) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                frame_done_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            x_start_q    <= '0;
            y_start_q    <= '0;
            step_q       <= '0;
            width_q      <= '0;
            height_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            max_iter_q   <= '0;
            cbusy_q      <= '0;
            armed_q      <= '0;
            start_q      <= '0;
            tag_col_q    <= '0;
            tag_row_q    <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            res_valid_q  <= 1'b0;
            res_col_q    <= '0;
            res_row_q    <= '0;
            res_iter_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_start_q    <= x_start_d;
            y_start_q    <= y_start_d;
            step_q       <= step_d;
            width_q      <= width_d;
            height_q     <= height_d;
            col_q        <= col_d;
            row_q        <= row_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            max_iter_q   <= max_iter_d;
            cbusy_q      <= cbusy_d;
            armed_q      <= armed_d;
            start_q      <= start_d;
            tag_col_q    <= tag_col_d;
            tag_row_q    <= tag_row_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            res_valid_q  <= res_valid_d;
            res_col_q    <= res_col_d;
            res_row_q    <= res_row_d;
            res_iter_q   <= res_iter_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign start_o      = start_q;
    assign x0_o         = x0_q;
    assign y0_o         = y0_q;
    assign max_iter_o   = max_iter_q;
    assign res_valid_o  = res_valid_q;
    assign res_col_o    = res_col_q;
    assign res_row_o    = res_row_q;
    assign res_iter_o   = res_iter_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_fractal_dispatcher.sv
// Testbench for fractal_dispatcher: behavioural fractal cores with random
// latency, a scoreboard that derives each pixel's coordinate and iteration
// count arithmetically, and one task per scenario.
module tb_fractal_dispatcher;

    localparam int DW = 32;
    localparam int MW = 16;
    localparam int CC = 4;
    localparam int CW = 12;

    logic              clk;
    logic              rst;
    logic              frame_start;
    logic [DW-1:0]     x_start, y_start, step;
    logic [CW-1:0]     width, height;
    logic [MW-1:0]     max_iter;
    logic [CC-1:0]     start_o;
    logic [DW*CC-1:0]  x0_o, y0_o;
    logic [MW-1:0]     max_iter_o;
    logic [MW*CC-1:0]  iter_flat;
    logic [CC-1:0]     m_done;
    logic              res_valid_o, res_ready;
    logic [CW-1:0]     res_col_o, res_row_o;
    logic [MW-1:0]     res_iter_o;
    logic              busy_o, frame_done_o;

    int checks = 0;
    int errors = 0;

    fractal_dispatcher #(
        .DATA_WIDTH(DW), .MAX_ITER_WIDTH(MW), .CORE_COUNT(CC), .COORD_WIDTH(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .frame_start_i(frame_start),
        .x_start_i(x_start), .y_start_i(y_start), .step_i(step),
        .width_i(width), .height_i(height), .max_iter_i(max_iter),
        .start_o(start_o), .x0_o(x0_o), .y0_o(y0_o), .max_iter_o(max_iter_o),
        .iter_i(iter_flat), .done_i(m_done),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready),
        .res_col_o(res_col_o), .res_row_o(res_row_o), .res_iter_o(res_iter_o),
        .busy_o(busy_o), .frame_done_o(frame_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Stand-in for the core's escape-time result: any fixed function of (x,y)
    function automatic logic [MW-1:0] core_result(input logic [DW-1:0] x, input logic [DW-1:0] y);
        return x[27:12] ^ {y[19:12], y[27:20]} ^ 16'h5A3C;
    endfunction

    // Behavioural cores: done level stays high from the previous job until a new start
    int            lat_min = 1, lat_max = 4;
    int            m_cnt [CC];
    logic [MW-1:0] m_iter [CC];
    logic [DW-1:0] m_x [CC], m_y [CC];

    always @(posedge clk) begin
        for (int i = 0; i < CC; i++) begin
            if (rst) begin
                m_done[i] <= 1'b0;
                m_cnt[i]  <= 0;
                m_iter[i] <= '0;
            end else if (start_o[i]) begin
                m_done[i] <= 1'b0;
                m_cnt[i]  <= int'($urandom_range(lat_max, lat_min));
                m_x[i]    <= x0_o[i*DW +: DW];
                m_y[i]    <= y0_o[i*DW +: DW];
            end else if (m_cnt[i] == 1) begin
                m_done[i] <= 1'b1;
                m_iter[i] <= core_result(m_x[i], m_y[i]);
                m_cnt[i]  <= 0;
            end else if (m_cnt[i] > 1) begin
                m_cnt[i] <= m_cnt[i] - 1;
            end
        end
    end

    always_comb begin
        iter_flat = '0;
        for (int i = 0; i < CC; i++) iter_flat[i*MW +: MW] = m_iter[i];
    end

    // Scoreboard: pixel k of the raster is the k-th dispatch
    int            fr_w, fr_h;
    logic [DW-1:0] fr_xs, fr_ys, fr_step;
    logic          sb_clr = 1'b0;
    int            cyc = 0;
    int            disp_cnt, res_cnt, acc_cnt, fd_cnt;
    int            bad_coord, bad_iter, bad_res, dup_cnt, busy_viol, hold_viol, multi_start;
    int            disp_core [256];
    int            disp_cyc [256];
    logic [DW-1:0] disp_x [256], disp_y [256];
    int            appear_cyc [256];
    int            last_pix [CC];
    logic          prev_stall = 1'b0;
    logic [CW-1:0] prev_col, prev_row;
    logic [MW-1:0] prev_iter;
    int            sk, scol, srow, sp;
    logic [DW-1:0] sx, sy;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (sb_clr) begin
            disp_cnt = 0; res_cnt = 0; acc_cnt = 0; fd_cnt = 0;
            bad_coord = 0; bad_iter = 0; bad_res = 0; dup_cnt = 0;
            busy_viol = 0; hold_viol = 0; multi_start = 0;
            for (int i = 0; i < 256; i++) appear_cyc[i] = -1;
            for (int i = 0; i < CC; i++) last_pix[i] = -1;
        end else begin
            if ($countones(start_o) > 1) multi_start++;
            for (int i = 0; i < CC; i++) begin
                if (start_o[i] && fr_w > 0) begin
                    sk   = disp_cnt;
                    scol = sk % fr_w;
                    srow = sk / fr_w;
                    sx   = fr_xs + 32'(scol) * fr_step;
                    sy   = fr_ys + 32'(srow) * fr_step;
                    if (sk < 256) begin
                        disp_core[sk] = i;
                        disp_cyc[sk]  = cyc;
                        disp_x[sk]    = x0_o[i*DW +: DW];
                        disp_y[sk]    = y0_o[i*DW +: DW];
                    end
                    if (x0_o[i*DW +: DW] !== sx || y0_o[i*DW +: DW] !== sy) bad_coord++;
                    if (last_pix[i] >= 0 && last_pix[i] < 256 && appear_cyc[last_pix[i]] < 0) busy_viol++;
                    last_pix[i] = sk;
                    disp_cnt++;
                end
            end
            if (res_valid_o && !prev_stall) begin
                res_cnt++;
                scol = int'(res_col_o);
                srow = int'(res_row_o);
                sp   = srow * fr_w + scol;
                if (scol >= fr_w || srow >= fr_h || sp >= 256) bad_res++;
                else if (appear_cyc[sp] >= 0) dup_cnt++;
                else begin
                    appear_cyc[sp] = cyc;
                    if (res_iter_o !== core_result(fr_xs + 32'(scol) * fr_step,
                                                   fr_ys + 32'(srow) * fr_step)) bad_iter++;
                end
            end
            if (prev_stall && (!res_valid_o || res_col_o !== prev_col ||
                               res_row_o !== prev_row || res_iter_o !== prev_iter)) hold_viol++;
            if (res_valid_o && res_ready) acc_cnt++;
            if (frame_done_o) fd_cnt++;
        end
        prev_stall = res_valid_o && !res_ready;
        prev_col   = res_col_o;
        prev_row   = res_row_o;
        prev_iter  = res_iter_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int w, input int h, input logic [DW-1:0] xs,
                               input logic [DW-1:0] ys, input logic [DW-1:0] st,
                               input logic [MW-1:0] mi);
        fr_w = w; fr_h = h; fr_xs = xs; fr_ys = ys; fr_step = st;
        sb_clr = 1'b1;
        tick();
        sb_clr      = 1'b0;
        x_start     = xs;
        y_start     = ys;
        step        = st;
        width       = CW'(w);
        height      = CW'(h);
        max_iter    = mi;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output logic ok);
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            tick();
            if (frame_done_o) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (start_o !== '0) begin errors++; $display("FAIL reset_start: got %0h want 0", start_o); end
        checks++; if (res_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", res_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
        checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %0b want 0", frame_done_o); end
        checks++; if (max_iter_o !== '0) begin errors++; $display("FAIL reset_max_iter: got %0h want 0", max_iter_o); end
        checks++; if (x0_o !== '0 || y0_o !== '0) begin errors++; $display("FAIL reset_x0y0: got %0h/%0h want 0", x0_o, y0_o); end
        checks++; if (res_col_o !== '0 || res_row_o !== '0 || res_iter_o !== '0) begin errors++; $display("FAIL reset_res: got %0h/%0h/%0h want 0", res_col_o, res_row_o, res_iter_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_2x2();
        logic          ok;
        logic [DW-1:0] ex_x [4] = '{32'hFE000000, 32'hFE800000, 32'hFE000000, 32'hFE800000};
        logic [DW-1:0] ex_y [4] = '{32'hFF000000, 32'hFF000000, 32'hFF800000, 32'hFF800000};
        lat_min = 2; lat_max = 6;
        res_ready = 1'b1;
        start_frame(2, 2, 32'hFE000000, 32'hFF000000, 32'h00800000, 16'd100);
        wait_done(200, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_done: got %0b want 1", ok); end
        checks++; if (disp_cnt !== 4) begin errors++; $display("FAIL basic_disp_cnt: got %0d want 4", disp_cnt); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (disp_core[k] !== k) begin errors++; $display("FAIL basic_core[%0d]: got %0d want %0d", k, disp_core[k], k); end
            checks++; if (disp_x[k] !== ex_x[k] || disp_y[k] !== ex_y[k]) begin errors++; $display("FAIL basic_coord[%0d]: got %0h,%0h want %0h,%0h", k, disp_x[k], disp_y[k], ex_x[k], ex_y[k]); end
            checks++; if (disp_cyc[k] !== disp_cyc[0] + k) begin errors++; $display("FAIL basic_consecutive[%0d]: got %0d want %0d", k, disp_cyc[k], disp_cyc[0] + k); end
        end
        checks++; if (res_cnt !== 4 || acc_cnt !== 4) begin errors++; $display("FAIL basic_results: got %0d/%0d want 4/4", res_cnt, acc_cnt); end
        checks++; if (bad_iter !== 0 || bad_res !== 0 || dup_cnt !== 0) begin errors++; $display("FAIL basic_result_data: got iter=%0d tag=%0d dup=%0d want 0", bad_iter, bad_res, dup_cnt); end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL basic_frame_done: got %0d want 1", fd_cnt); end
        checks++; if (max_iter_o !== 16'd100) begin errors++; $display("FAIL basic_max_iter: got %0d want 100", max_iter_o); end
    endtask

    task automatic test_random_5x4();
        logic ok = 1'b0;
        lat_min = 1; lat_max = 8;
        res_ready = 1'b1;
        start_frame(5, 4, 32'h00000000 - 32'h01800000, 32'h00400000, 32'h00200000, 16'd500);
        for (int n = 0; n < 2000; n++) begin
            res_ready = ($urandom_range(3, 0) != 0);
            tick();
            if (frame_done_o) begin
                ok = 1'b1;
                break;
            end
        end
        res_ready = 1'b1;
        repeat (3) tick();
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rand_done: got %0b want 1", ok); end
        checks++; if (disp_cnt !== 20) begin errors++; $display("FAIL rand_disp_cnt: got %0d want 20", disp_cnt); end
        checks++; if (res_cnt !== 20 || acc_cnt !== 20) begin errors++; $display("FAIL rand_results: got %0d/%0d want 20/20", res_cnt, acc_cnt); end
        checks++; if (dup_cnt !== 0 || bad_res !== 0) begin errors++; $display("FAIL rand_tags: got dup=%0d bad=%0d want 0", dup_cnt, bad_res); end
        checks++; if (bad_iter !== 0) begin errors++; $display("FAIL rand_iter: got %0d bad want 0", bad_iter); end
        checks++; if (bad_coord !== 0) begin errors++; $display("FAIL rand_coord: got %0d bad want 0", bad_coord); end
        checks++; if (busy_viol !== 0 || multi_start !== 0) begin errors++; $display("FAIL rand_start_busy: got %0d/%0d want 0/0", busy_viol, multi_start); end
        checks++; if (hold_viol !== 0) begin errors++; $display("FAIL rand_hold: got %0d want 0", hold_viol); end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL rand_frame_done: got %0d want 1", fd_cnt); end
    endtask

    task automatic test_stall();
        logic ok;
        int   d7 = 0;
        lat_min = 1; lat_max = 3;
        res_ready = 1'b1;
        start_frame(6, 3, 32'h7F000000, 32'h80000000, 32'h00C00000, 16'd64);
        repeat (6) tick();
        res_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
            tick();
            if (s == 7) d7 = disp_cnt;
        end
        checks++; if (start_o !== '0) begin errors++; $display("FAIL stall_start: got %0h want 0", start_o); end
        checks++; if (res_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid: got %0b want 1", res_valid_o); end
        checks++; if (disp_cnt !== d7) begin errors++; $display("FAIL stall_dispatch: got %0d want %0d", disp_cnt, d7); end
        res_ready = 1'b1;
        wait_done(400, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_done: got %0b want 1", ok); end
        checks++; if (res_cnt !== 18 || acc_cnt !== 18) begin errors++; $display("FAIL stall_results: got %0d/%0d want 18/18", res_cnt, acc_cnt); end
        checks++; if (hold_viol !== 0) begin errors++; $display("FAIL stall_hold: got %0d want 0", hold_viol); end
        checks++; if (dup_cnt !== 0 || bad_iter !== 0 || bad_res !== 0 || bad_coord !== 0) begin errors++; $display("FAIL stall_data: got dup=%0d iter=%0d tag=%0d coord=%0d want 0", dup_cnt, bad_iter, bad_res, bad_coord); end
        checks++; if (busy_viol !== 0) begin errors++; $display("FAIL stall_busy: got %0d want 0", busy_viol); end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL stall_frame_done: got %0d want 1", fd_cnt); end
    endtask

    task automatic test_zero_dim();
        res_ready = 1'b1;
        start_frame(0, 3, 32'h01000000, 32'h01000000, 32'h00100000, 16'd7);
        checks++; if (busy_o !== 1'b1 || frame_done_o !== 1'b0) begin errors++; $display("FAIL zero_cycle1: got busy=%0b done=%0b want 1/0", busy_o, frame_done_o); end
        tick();
        checks++; if (busy_o !== 1'b0 || frame_done_o !== 1'b1) begin errors++; $display("FAIL zero_cycle2: got busy=%0b done=%0b want 0/1", busy_o, frame_done_o); end
        tick();
        checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL zero_cycle3: got done=%0b want 0", frame_done_o); end
        repeat (3) tick();
        checks++; if (disp_cnt !== 0 || fd_cnt !== 1) begin errors++; $display("FAIL zero_counts: got disp=%0d fd=%0d want 0/1", disp_cnt, fd_cnt); end
    endtask

    task automatic test_restart_ignored();
        logic ok;
        lat_min = 2; lat_max = 6;
        res_ready = 1'b1;
        start_frame(4, 3, 32'hFF000000, 32'h00800000, 32'h00400000, 16'd33);
        repeat (4) tick();
        x_start     = 32'h12345678;
        y_start     = 32'h00000000;
        step        = 32'h00010000;
        width       = CW'(1);
        height      = CW'(1);
        max_iter    = 16'd999;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wait_done(400, ok);
        repeat (10) tick();
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL restart_done: got %0b want 1", ok); end
        checks++; if (disp_cnt !== 12 || res_cnt !== 12) begin errors++; $display("FAIL restart_counts: got %0d/%0d want 12/12", disp_cnt, res_cnt); end
        checks++; if (bad_coord !== 0 || bad_iter !== 0 || dup_cnt !== 0) begin errors++; $display("FAIL restart_data: got coord=%0d iter=%0d dup=%0d want 0", bad_coord, bad_iter, dup_cnt); end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL restart_frame_done: got %0d want 1", fd_cnt); end
        checks++; if (max_iter_o !== 16'd33) begin errors++; $display("FAIL restart_max_iter: got %0d want 33", max_iter_o); end
    endtask

    task automatic test_reset_midrun();
        logic ok;
        logic got3 = 1'b0;
        lat_min = 20; lat_max = 30;
        res_ready = 1'b1;
        start_frame(8, 2, 32'h00000000, 32'h00000000, 32'h00100000, 16'd50);
        for (int n = 0; n < 50; n++) begin
            tick();
            if (disp_cnt >= 3) begin
                got3 = 1'b1;
                break;
            end
        end
        checks++; if (got3 !== 1'b1) begin errors++; $display("FAIL midrst_dispatch: got %0d dispatches want >=3", disp_cnt); end
        rst = 1'b1;
        tick();
        checks++; if (start_o !== '0 || res_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got start=%0h valid=%0b want 0/0", start_o, res_valid_o); end
        checks++; if (busy_o !== 1'b0 || frame_done_o !== 1'b0) begin errors++; $display("FAIL midrst_status: got busy=%0b done=%0b want 0/0", busy_o, frame_done_o); end
        rst = 1'b0;
        tick();
        lat_min = 1; lat_max = 4;
        start_frame(1, 1, 32'h00400000, 32'hFFC00000, 32'h00100000, 16'd9);
        wait_done(100, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL after_rst_done: got %0b want 1", ok); end
        checks++; if (disp_cnt !== 1 || res_cnt !== 1 || acc_cnt !== 1) begin errors++; $display("FAIL after_rst_counts: got %0d/%0d/%0d want 1/1/1", disp_cnt, res_cnt, acc_cnt); end
        checks++; if (bad_coord !== 0 || bad_iter !== 0 || bad_res !== 0) begin errors++; $display("FAIL after_rst_data: got coord=%0d iter=%0d tag=%0d want 0", bad_coord, bad_iter, bad_res); end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL after_rst_frame_done: got %0d want 1", fd_cnt); end
    endtask

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        x_start     = '0;
        y_start     = '0;
        step        = '0;
        width       = '0;
        height      = '0;
        max_iter    = '0;
        res_ready   = 1'b1;
        fr_w = 0; fr_h = 0; fr_xs = '0; fr_ys = '0; fr_step = '0;
        test_reset();
        test_basic_2x2();
        test_random_5x4();
        test_stall();
        test_zero_dim();
        test_restart_ignored();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fractal_dispatcher.md
Name: fractal_dispatcher

Overview:
Feeds the fractal core array and collects its results. Scans a frame in raster order and hands each pixel's complex coordinate to an idle core with a one-cycle start pulse. When the core reports done, reads the iteration count back and emits it as a tagged (col,row,iter) result on a valid/ready stream for the framebuffer writer. Results may leave out of order; every result carries its own pixel coordinates.

Parameters:
DATA_WIDTH, 32, signed fixed-point coordinate width (8.24)
MAX_ITER_WIDTH, 16, iteration count width
CORE_COUNT, 16, number of cores driven (bit i maps to core i)
COORD_WIDTH, 12, pixel column/row counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset (see below)
frame_start_i  in  1  start-of-frame pulse; sampled only in IDLE
x_start_i  in  DATA_WIDTH  signed real coordinate of column 0
y_start_i  in  DATA_WIDTH  signed imaginary coordinate of row 0
step_i  in  DATA_WIDTH  signed per-pixel increment (both axes)
width_i  in  COORD_WIDTH  columns per frame
height_i  in  COORD_WIDTH  rows per frame
max_iter_i  in  MAX_ITER_WIDTH  iteration limit, passed through
start_o  out  CORE_COUNT  per-core one-cycle start pulse
x0_o  out  DATA_WIDTH*CORE_COUNT  packed per-core real coordinate; slice i = [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
y0_o  out  DATA_WIDTH*CORE_COUNT  packed per-core imaginary coordinate; same slicing
max_iter_o  out  MAX_ITER_WIDTH  latched max_iter for the frame
iter_i  in  MAX_ITER_WIDTH*CORE_COUNT  packed per-core iteration results
done_i  in  CORE_COUNT  per-core done level
res_valid_o  out  1  result valid
res_ready_i  in  1  downstream ready
res_col_o  out  COORD_WIDTH  result pixel column
res_row_o  out  COORD_WIDTH  result pixel row
res_iter_o  out  MAX_ITER_WIDTH  result iteration count
busy_o  out  1  high in any state but IDLE
frame_done_o  out  1  one-cycle pulse when the frame completes

Behaviour:
- One clock (clk_i). Reset is synchronous, active-high (rst_i). Reset zeroes all outputs, all per-core state and all counters. FSM goes to IDLE.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on frame_start_i. This latches x_start, y_start, step, width, height and max_iter. It also sets col=row=0, cur_x=x_start, cur_y=y_start.
- IDLE -> DONE instead if width_i==0 or height_i==0. No dispatch happens.
- frame_start_i outside IDLE is ignored.
- Per-core state: busy, armed, col tag, row tag, x0 reg, y0 reg.
- Dispatch happens in RUN, at most one per cycle, to the lowest-index core with busy==0:
  - Register x0/y0 slice = cur_x/cur_y and tags = col/row.
  - Set busy; clear armed; pulse start_o[i] for exactly one cycle, aligned with the new x0/y0.
  - Advance raster: col+1 and cur_x+=step. At col==width-1: col=0, cur_x=x_start, row+1, cur_y+=step.
- Coordinate adds wrap modulo 2^DATA_WIDTH (two's complement). No saturation.
- After dispatching pixel (width-1,height-1): RUN -> DRAIN.
- armed is set the cycle after start_o[i]. done_i[i] is honoured only when busy[i] && armed[i]; this masks the stale done level from the previous job.
- Collection: a core with busy && armed && done_i is pending. When the output register is empty, or is being consumed this cycle (res_valid_o && res_ready_i), the lowest-index pending core is captured:
  - res_col/row = tags; res_iter = iter_i slice.
  - That core's busy clears the same cycle, so it is re-dispatchable the next cycle.
- Throughput: at most one collection per cycle. The output register holds a single entry.
- res_* outputs stay stable while res_valid_o && !res_ready_i.
- A core may be dispatched and another collected in the same cycle. A core freed by collection is not re-dispatched in that same cycle.
- DRAIN -> DONE when no core is busy and res_valid_o is low, or the final result is being accepted this cycle.
- DONE: frame_done_o=1 for one cycle, then -> IDLE.
- max_iter_o is held from the latch until the next frame.
- Reset mid-frame aborts: all busy flags are cleared and start_o=0. The cores are expected to receive the same rst_i.

Test Plan:
- 2x2 frame, x_start=-2.0 (0xFE000000), y_start=-1.0, step=0.5, 16 cores, res_ready=1 -> start_o pulses cores 0..3 on consecutive cycles with x0 = -2.0, -1.5, -2.0, -1.5 and y0 = -1.0, -1.0, -0.5, -0.5. Four results with tags (0,0),(1,0),(0,1),(1,1) and iter matching model done data. frame_done_o pulses once.
- 5x4 frame with CORE_COUNT=4 and model cores at randomised latencies -> exactly 20 results, each (col,row) seen once, no start_o to a busy core, and a stale done_i in the cycle after start is ignored.
- res_ready_i low for 10 cycles mid-frame -> res_* held stable and no results lost. Cores stay busy until collected, and dispatch stalls once all cores are busy.
- width_i=0 with frame_start_i -> no start_o; frame_done_o pulses 2 cycles after the start, busy_o high for 1 cycle.
- frame_start_i pulsed during RUN -> ignored: the raster continues unchanged and exactly one frame_done_o pulse occurs.
- rst_i asserted in RUN with 3 cores busy -> the next cycle shows start_o=0, res_valid_o=0, busy_o=0, IDLE. A following 1x1 frame completes normally.
